// File: rtl/aes_encrypt_round_core.sv
// Iterative AES-128 encryption core fed by KeySchedule round keys; one round per clock.
// Define AES_CORE_TWO_ROUND_EN to chain two rounds per clock (five-cycle latency).
module aes_encrypt_round_core (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          key_ready,
  input  logic [127:0]  key,
  input  logic [1279:0] roundkeys,
  input  logic [127:0]  plaintext,
  output logic [127:0]  ciphertext,
  output logic          busy,
  output logic          finish
);

  typedef enum logic [1:0] {IDLE, WAIT_KEY, ROUND, DONE} fsm_t;

  localparam logic [0:255][7:0] SBOX = 2048'h637c777bf26b6fc53001672bfed7ab76_ca82c97dfa5947f0add4a2af9ca472c0_b7fd9326363ff7cc34a5e5f171d83115_04c723c31896059a071280e2eb27b275_09832c1a1b6e5aa0523bd6b329e32f84_53d100ed20fcb15b6acbbe394a4c58cf_d0efaafb434d338545f9027f503c9fa8_51a3408f929d38f5bcb6da2110fff3d2_cd0c13ec5f974417c4a77e3d645d1973_60814fdc222a908846eeb814de5e0bdb_e0323a0a4906245cc2d3ac629195e479_e7c8376d8dd54ea96c56f4ea657aae08_ba78252e1ca6b4c6e8dd741f4bbd8b8a_703eb5664803f60e613557b986c11d9e_e1f8981169d98e949b1e87e9ce5528df_8ca1890dbfe6426841992d0fb054bb16;

`ifdef AES_CORE_TWO_ROUND_EN
  localparam logic [3:0] STEP = 4'd2;
`else
  localparam logic [3:0] STEP = 4'd1;
`endif

  fsm_t          fsm_q, fsm_d;
  logic [127:0]  state_q, state_d;
  logic [3:0]    round_q, round_d;
  logic [127:0]  ct_q, ct_d;
  logic          start_d, key_ready_d;
  logic          start_rise, last_round;
  logic [127:0]  round_res;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // SubBytes, ShiftRows, optional MixColumns, AddRoundKey; byte i sits at [127-8i -: 8].
  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [127:0] sb, sr, mc;
    logic [7:0]   a0, a1, a2, a3;
    for (int i = 0; i < 16; i++) sb[127-8*i -: 8] = SBOX[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
    for (int c = 0; c < 4; c++) begin
      a0 = sr[127-32*c -: 8];
      a1 = sr[119-32*c -: 8];
      a2 = sr[111-32*c -: 8];
      a3 = sr[103-32*c -: 8];
      mc[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return (last ? sr : mc) ^ rk;
  endfunction

  function automatic logic [127:0] rk_sel(input logic [3:0] rnd, input logic [1279:0] rks);
    logic [127:0] rk;
    rk = '0;
    for (int i = 1; i <= 10; i++)
      if (rnd == i[3:0]) rk = rks[(10-i)*128 +: 128];
    return rk;
  endfunction

  assign start_rise = start & ~start_d;

`ifdef AES_CORE_TWO_ROUND_EN
  logic [127:0] mid_res;
  always_comb begin
    last_round = (round_q == 4'd9);
    mid_res    = enc_round(state_q, rk_sel(round_q, roundkeys), 1'b0);
    round_res  = enc_round(mid_res, rk_sel(round_q + 4'd1, roundkeys), last_round);
  end
`else
  always_comb begin
    last_round = (round_q == 4'd10);
    round_res  = enc_round(state_q, rk_sel(round_q, roundkeys), last_round);
  end
`endif

  // A key_ready that rises on the same edge as the request is only honoured one edge later.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    round_d = round_q;
    ct_d    = ct_q;
    case (fsm_q)
      IDLE, DONE: begin
        if (start_rise) begin
          if (key_ready && key_ready_d) begin
            state_d = plaintext ^ key;
            round_d = 4'd1;
            fsm_d   = ROUND;
          end else begin
            state_d = plaintext;
            fsm_d   = WAIT_KEY;
          end
        end
      end
      WAIT_KEY: begin
        if (key_ready) begin
          state_d = state_q ^ key;
          round_d = 4'd1;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        state_d = round_res;
        if (last_round) begin
          ct_d    = round_res;
          round_d = 4'd0;
          fsm_d   = DONE;
        end else begin
          round_d = round_q + STEP;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      round_q     <= '0;
      ct_q        <= '0;
      start_d     <= 1'b0;
      key_ready_d <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      round_q     <= round_d;
      ct_q        <= ct_d;
      start_d     <= start;
      key_ready_d <= key_ready;
    end
  end

  assign ciphertext = ct_q;
  assign busy       = (fsm_q == WAIT_KEY) || (fsm_q == ROUND);
  assign finish     = (fsm_q == DONE);

endmodule

// File: doc/aes_encrypt_round_core.md
# aes_encrypt_round_core

Iterative AES-128 encryption datapath directly downstream of `KeySchedule`. It consumes the 1280-bit `roundkeys` bus and `finish` flag that `KeySchedule` produces, plus the original cipher key and a 128-bit plaintext. It performs one cipher round per clock and reports completion with a `finish` level, using the same start/finish handshake style as `KeySchedule`.

## Interface
- No parameters.
- `clk  input  1  rising-edge clock`
- `rst  input  1  reset, asynchronous, active-low (asserted when 0)`
- `start  input  1  request; only a rising edge (0→1 across two samples) is a request`
- `key_ready  input  1  KeySchedule `finish`; roundkeys valid while high`
- `key  input  128  cipher key = round key 0`
- `roundkeys  input  1280  round keys 1..10; [1279:1152]=RK1 … [127:0]=RK10`
- `plaintext  input  128  sampled on the accepting edge; byte 0 = [127:120], column-major per FIPS-197`
- `ciphertext  output  128  result; valid while `finish`=1`
- `busy  output  1  high in WAIT_KEY and ROUND`
- `finish  output  1  high in DONE`

## Operation
- States: IDLE, WAIT_KEY, ROUND, DONE.
- Rising-edge detect: register `start_d`; `start_rise = start & ~start_d`. `start_d` resets to 0.
- IDLE or DONE, `start_rise`:
  - With `key_ready`=1: state ← `plaintext ^ key`, round ← 1, go to ROUND.
  - Otherwise: latch `plaintext` into the state register, go to WAIT_KEY.
- WAIT_KEY: on the first edge with `key_ready`=1, state ← state ^ `key`, round ← 1, go to ROUND.
- ROUND, rounds 1..9: state ← MixColumns(ShiftRows(SubBytes(state))) ^ RK[round]; round increments.
- ROUND, round 10: MixColumns is omitted. The result is loaded into `ciphertext`, round ← 0, go to DONE.
- DONE:
  - `finish`=1 and `ciphertext` is held.
  - Leaves only on the next `start_rise`, which restarts exactly as from IDLE and clears `finish` on that edge.
- S-box is combinational: 16 instances, or 32 with the configuration macro.
- The block does not latch `roundkeys` or `key`. Upstream holds them stable from accept until `finish`.
- Round counter: 4 bits, range 0..10; never wraps past 10.

## Timing
- Reset values: `ciphertext`=0, `busy`=0, `finish`=0, state register=0, round=0, FSM=IDLE.
- Reset mid-operation aborts immediately (asynchronous), with no partial output.
- Latency, counted from the accepting edge T0 (key already ready):
  - `busy` rises at T0.
  - `finish` and `ciphertext` are valid after T10, i.e. 10 cycles after T0.
  - `busy` falls at T10.
- If waiting for the key: T0 is the edge where `key_ready` is first seen high in WAIT_KEY.
- Ignored events:
  - `start_rise` during WAIT_KEY or ROUND.
  - A `start` held high across DONE; a new request needs 0 then 1.
  - `key_ready` falling during ROUND.
- Simultaneous `start_rise` and `key_ready` rise on the same edge in IDLE: goes to WAIT_KEY. `key_ready` is seen on the next edge, adding 1 cycle.

## Configuration
- `AES_CORE_TWO_ROUND_EN`
  - Defined: two rounds are chained combinationally per clock (round pairs 1–2 … 9–10). Round 10, the second half of cycle 5, skips MixColumns. Round increments by 2. `finish` comes 5 cycles after T0.
  - Undefined: one round per clock, 10-cycle latency as above.
- Handshake, reset values and ignore rules are identical in both builds.

## Test plan
- FIPS-197 App. B:
  - Stimulus: key `2b7e151628aed2a6abf7158809cf4f3c`, pt `3243f6a8885a308d313198a2e0370734`, `key_ready`=1 before start.
  - Response: ct `3925841d02dc09fbdc118597196a0b32`, `finish` exactly 10 cycles after accept (5 with the macro).
- FIPS-197 App. C.1:
  - Stimulus: key `000102…0f`, pt `00112233445566778899aabbccddeeff`, driven by a real `KeySchedule` instance with start issued before its `finish`.
  - Response: ct `69c4e0d86a7b0430d8cdb78070b4c55a`, `busy`=1 throughout WAIT_KEY.
- Start held high 20 cycles past DONE:
  - Response: exactly one encryption; `finish` stays 1 and `ciphertext` is stable.
  - Then drop `start` and raise it again: second encryption of a new pt gives the correct ct.
- `start_rise` pulsed at round 4 with a different plaintext:
  - Response: ignored; ct matches the first plaintext.
- `rst`=0 asserted at round 6:
  - Response: outputs 0 immediately, no `finish`.
  - After release, a fresh App. B run passes.
- All-zero key and all-zero pt:
  - Response: ct `66e94bd4ef8a2c3b884cfa59ca342b2e`.
